// File: rtl/fifo_rd_prefetch_ctl.sv
// LCD-side read controller for the async pixel FIFO. It waits for a start
// level, primes a 2-entry prefetch buffer, then serves one pixel per LCD
// request with a fixed 1-cycle latency. It also tracks underflows.
module fifo_rd_prefetch_ctl #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    CNT_WIDTH      = 10,
  parameter int                    START_LEVEL    = 256,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_FILL = '0
) (
  input  logic                  fifo_rd_clk,
  input  logic                  rst_n,
  input  logic                  ctl_en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [CNT_WIDTH-1:0]  fifo_rd_cnt,
  input  logic                  lcd_data_requst,
  output logic [DATA_WIDTH-1:0] lcd_data,
  output logic                  lcd_data_valid,
  output logic                  underflow,
  output logic [15:0]           underflow_cnt,
  input  logic                  underflow_clr,
  output logic [1:0]            ctl_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] START_CMP = START_LEVEL[CNT_WIDTH-1:0];

  state_t                state;
  state_t                state_next;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic                  pop;
  logic [2:0]            level;
  logic                  space;
  logic                  uf_event;

  assign ctl_state = state;

  // State register; a low enable or reset always lands in IDLE.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus the read strobe: read only when the word still fits after this cycle's pop.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    level      = 3'd0;
    space      = 1'b0;
    fifo_rd_en = 1'b0;
    uf_event   = 1'b0;

    pop      = lcd_data_requst && (occ != 2'd0) && (state == RUN);
    uf_event = lcd_data_requst && (occ == 2'd0) && (state == RUN);
    level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    space    = (level < 3'd2);

    if (!fifo_empty && space) begin
      if (state == RUN)
        fifo_rd_en = 1'b1;
      else if (state == PRIME && fifo_rd_cnt >= START_CMP)
        fifo_rd_en = 1'b1;
    end

    case (state)
      IDLE:    if (ctl_en) state_next = PRIME;
      PRIME:   if (occ == 2'd2) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase

    if (!ctl_en) state_next = IDLE;
  end

  // Prefetch buffer: head/tail pair with simultaneous pop and write support; flush drops everything.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf_head <= '0;
      buf_tail <= '0;
    end else if (!ctl_en) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      case ({pop, inflight})
        2'b10: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) buf_head <= fifo_rd_data;
          else             buf_tail <= fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= fifo_rd_data;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // LCD output register: every request answers next cycle, with the fill pixel if nothing can be served.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_data       <= UNDERFLOW_FILL;
      lcd_data_valid <= 1'b0;
    end else begin
      lcd_data_valid <= lcd_data_requst;
      if (lcd_data_requst)
        lcd_data <= pop ? buf_head : UNDERFLOW_FILL;
    end
  end

  // Underflow flag and saturating count; a clear coinciding with a new underflow records that underflow.
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= 16'd0;
    end else if (underflow_clr) begin
      underflow     <= uf_event;
      underflow_cnt <= {15'd0, uf_event};
    end else if (uf_event) begin
      underflow <= 1'b1;
      if (underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_prefetch_ctl.sv
// Self-checking bench for fifo_rd_prefetch_ctl: a queue-based FIFO source
// feeds the DUT and a queue-based behavioural model predicts every output.
module tb_fifo_rd_prefetch_ctl;

  localparam int          DW    = 16;
  localparam int          CW    = 10;
  localparam int          START = 256;
  localparam logic [15:0] FILL  = 16'h0000;

  logic          fifo_rd_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ctl_en = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic [CW-1:0] fifo_rd_cnt = '0;
  logic          lcd_data_requst = 1'b0;
  logic [DW-1:0] lcd_data;
  logic          lcd_data_valid;
  logic          underflow;
  logic [15:0]   underflow_cnt;
  logic          underflow_clr = 1'b0;
  logic [1:0]    ctl_state;

  int vectors     = 0;
  int miscompares = 0;

  // FIFO source contents and an optional forced occupancy value
  logic [DW-1:0] src_q[$];
  bit            cnt_force     = 1'b0;
  int            cnt_force_val = 0;

  // Reference model: state as 0/1/2, buffer as a queue
  int            m_state;
  logic [DW-1:0] m_buf[$];
  bit            m_infl;
  logic [DW-1:0] m_lcd_data;
  bit            m_valid;
  bit            m_uf;
  int            m_uf_cnt;

  fifo_rd_prefetch_ctl #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .START_LEVEL(START), .UNDERFLOW_FILL(FILL)
  ) dut (
    .fifo_rd_clk(fifo_rd_clk), .rst_n(rst_n), .ctl_en(ctl_en),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_rd_cnt(fifo_rd_cnt),
    .lcd_data_requst(lcd_data_requst), .lcd_data(lcd_data),
    .lcd_data_valid(lcd_data_valid), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .underflow_clr(underflow_clr),
    .ctl_state(ctl_state)
  );

  always #5 fifo_rd_clk = ~fifo_rd_clk;

  function automatic void model_reset();
    m_state    = 0;
    m_buf.delete();
    m_infl     = 1'b0;
    m_lcd_data = FILL;
    m_valid    = 1'b0;
    m_uf       = 1'b0;
    m_uf_cnt   = 0;
  endfunction

  task automatic drive_flags();
    int sz;
    sz = src_q.size();
    fifo_empty = (sz == 0);
    if (cnt_force)     fifo_rd_cnt = CW'(cnt_force_val);
    else if (sz > 1023) fifo_rd_cnt = CW'(1023);
    else               fifo_rd_cnt = CW'(sz);
  endtask

  // One clock cycle: drive inputs, check the read strobe, advance the model, check registered outputs
  task automatic run_cycle(input bit req, input bit en, input bit clr);
    bit            exp_rd;
    bit            act_rd;
    bit            pop;
    bit            uf;
    int            lvl;
    int            ns;
    logic [DW-1:0] bus;

    @(negedge fifo_rd_clk);
    lcd_data_requst = req;
    ctl_en          = en;
    underflow_clr   = clr;
    drive_flags();
    #1;

    pop    = req && (m_buf.size() != 0) && (m_state == 2);
    uf     = req && (m_buf.size() == 0) && (m_state == 2);
    lvl    = m_buf.size() + int'(m_infl) - int'(pop);
    exp_rd = !fifo_empty && (lvl < 2) &&
             ((m_state == 1 && int'(fifo_rd_cnt) >= START) || m_state == 2);
    act_rd = fifo_rd_en;
    vectors++;
    if (fifo_rd_en !== exp_rd) begin
      miscompares++;
      $display("[TB] FAIL fifo_rd_en @%0t: got %b expected %b", $time, fifo_rd_en, exp_rd);
    end
    bus = fifo_rd_data;

    if (req) begin
      m_valid    = 1'b1;
      m_lcd_data = pop ? m_buf[0] : FILL;
    end else begin
      m_valid = 1'b0;
    end
    if (clr) begin
      m_uf     = uf;
      m_uf_cnt = int'(uf);
    end else if (uf) begin
      m_uf = 1'b1;
      if (m_uf_cnt < 65535) m_uf_cnt++;
    end
    if (!en) begin
      m_state = 0;
      m_buf.delete();
      m_infl = 1'b0;
    end else begin
      if (m_state == 0)                          ns = 1;
      else if (m_state == 1 && m_buf.size() == 2) ns = 2;
      else                                        ns = m_state;
      if (pop)    void'(m_buf.pop_front());
      if (m_infl) m_buf.push_back(bus);
      m_infl  = exp_rd;
      m_state = ns;
    end

    @(posedge fifo_rd_clk);
    #1;
    if (act_rd && src_q.size() > 0) fifo_rd_data = src_q.pop_front();
    else                            fifo_rd_data = DW'($urandom);

    vectors++;
    if (lcd_data_valid !== m_valid) begin
      miscompares++;
      $display("[TB] FAIL lcd_data_valid @%0t: got %b expected %b", $time, lcd_data_valid, m_valid);
    end
    vectors++;
    if (lcd_data !== m_lcd_data) begin
      miscompares++;
      $display("[TB] FAIL lcd_data @%0t: got %h expected %h", $time, lcd_data, m_lcd_data);
    end
    vectors++;
    if (underflow !== m_uf) begin
      miscompares++;
      $display("[TB] FAIL underflow @%0t: got %b expected %b", $time, underflow, m_uf);
    end
    vectors++;
    if (underflow_cnt !== 16'(m_uf_cnt)) begin
      miscompares++;
      $display("[TB] FAIL underflow_cnt @%0t: got %h expected %h", $time, underflow_cnt, 16'(m_uf_cnt));
    end
    vectors++;
    if (ctl_state !== 2'(m_state)) begin
      miscompares++;
      $display("[TB] FAIL ctl_state @%0t: got %0d expected %0d", $time, ctl_state, m_state);
    end
  endtask

  // Reset values are visible immediately and the read strobe stays low while held
  task automatic check_reset_values(input string tag);
    vectors++;
    if (fifo_rd_en !== 1'b0 || lcd_data !== FILL || lcd_data_valid !== 1'b0 ||
        underflow !== 1'b0 || underflow_cnt !== 16'd0 || ctl_state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL %s: got rd_en=%b data=%h valid=%b uf=%b cnt=%h st=%0d expected all reset values",
               tag, fifo_rd_en, lcd_data, lcd_data_valid, underflow, underflow_cnt, ctl_state);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_values("reset_initial");
    @(posedge fifo_rd_clk);
    #1;
    check_reset_values("reset_held");
    @(negedge fifo_rd_clk);
    rst_n = 1'b1;
    run_cycle(0, 0, 0);
  endtask

  task automatic test_prime_threshold();
    int n;
    $display("[TB] test_prime_threshold");
    for (int i = 1; i <= 64; i++) src_q.push_back(DW'(i));
    cnt_force     = 1'b1;
    cnt_force_val = START - 1;
    for (int i = 0; i < 8; i++) run_cycle(0, 1, 0);
    vectors++;
    if (ctl_state !== 2'd1 || src_q.size() != 64) begin
      miscompares++;
      $display("[TB] FAIL prime_below_level: got state=%0d src_left=%0d expected 1 64", ctl_state, src_q.size());
    end
    cnt_force_val = START;
    n = 0;
    while (ctl_state !== 2'd2 && n < 20) begin
      run_cycle(0, 1, 0);
      n++;
    end
    vectors++;
    if (n != 4 || src_q.size() != 62) begin
      miscompares++;
      $display("[TB] FAIL prime_to_run: got cycles=%0d src_left=%0d expected 4 62", n, src_q.size());
    end
    cnt_force = 1'b0;
  endtask

  task automatic test_stream_order();
    $display("[TB] test_stream_order");
    for (int i = 0; i < 64; i++) begin
      run_cycle(1, 1, 0);
      vectors++;
      if (lcd_data_valid !== 1'b1 || lcd_data !== DW'(i + 1)) begin
        miscompares++;
        $display("[TB] FAIL stream_word%0d: got valid=%b data=%h expected 1 %h", i, lcd_data_valid, lcd_data, DW'(i + 1));
      end
    end
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stream_underflow: got %b expected 0", underflow);
    end
  endtask

  task automatic test_underflow();
    $display("[TB] test_underflow");
    for (int i = 0; i < 5; i++) begin
      run_cycle(1, 1, 0);
      vectors++;
      if (lcd_data !== FILL || lcd_data_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL underflow_fill%0d: got data=%h valid=%b expected %h 1", i, lcd_data, lcd_data_valid, FILL);
      end
    end
    vectors++;
    if (underflow !== 1'b1 || underflow_cnt !== 16'd5) begin
      miscompares++;
      $display("[TB] FAIL underflow_count: got flag=%b cnt=%0d expected 1 5", underflow, underflow_cnt);
    end
    run_cycle(0, 1, 1);
    vectors++;
    if (underflow !== 1'b0 || underflow_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL underflow_clear: got flag=%b cnt=%0d expected 0 0", underflow, underflow_cnt);
    end
    run_cycle(1, 1, 1);
    vectors++;
    if (underflow !== 1'b1 || underflow_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL clear_with_new_underflow: got flag=%b cnt=%0d expected 1 1", underflow, underflow_cnt);
    end
    run_cycle(0, 1, 1);
  endtask

  task automatic test_saturation();
    $display("[TB] test_saturation");
    for (int i = 0; i < 65537; i++) run_cycle(1, 1, 0);
    vectors++;
    if (underflow_cnt !== 16'hFFFF || underflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL underflow_saturate: got cnt=%h flag=%b expected ffff 1", underflow_cnt, underflow);
    end
    run_cycle(0, 1, 1);
  endtask

  task automatic test_write_into_empty();
    $display("[TB] test_write_into_empty");
    src_q.push_back(16'hBEEF);
    run_cycle(0, 1, 0);
    run_cycle(1, 1, 0);
    vectors++;
    if (lcd_data !== FILL || underflow_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL write_empty_underflow: got data=%h cnt=%0d expected %h 1", lcd_data, underflow_cnt, FILL);
    end
    run_cycle(1, 1, 0);
    vectors++;
    if (lcd_data !== 16'hBEEF || lcd_data_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL write_empty_served: got data=%h valid=%b expected beef 1", lcd_data, lcd_data_valid);
    end
    run_cycle(0, 1, 1);
  endtask

  task automatic test_flush_reenable();
    logic [DW-1:0] exp_first;
    int            n;
    $display("[TB] test_flush_reenable");
    for (int k = 0; k < 10; k++) src_q.push_back(DW'(16'h1000 + k));
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 0);
    run_cycle(1, 1, 0);
    run_cycle(0, 0, 0);
    vectors++;
    if (ctl_state !== 2'd0 || fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_idle: got state=%0d rd_en=%b expected 0 0", ctl_state, fifo_rd_en);
    end
    exp_first     = src_q[0];
    cnt_force     = 1'b1;
    cnt_force_val = START;
    n = 0;
    while (ctl_state !== 2'd2 && n < 20) begin
      run_cycle(0, 1, 0);
      n++;
    end
    vectors++;
    if (ctl_state !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL reprime_timeout: got state=%0d expected 2", ctl_state);
    end
    cnt_force = 1'b0;
    run_cycle(1, 1, 0);
    vectors++;
    if (lcd_data !== exp_first) begin
      miscompares++;
      $display("[TB] FAIL flush_first_word: got %h expected %h", lcd_data, exp_first);
    end
  endtask

  task automatic test_reset_mid_run();
    $display("[TB] test_reset_mid_run");
    for (int k = 0; k < 6; k++) src_q.push_back(DW'(16'h2000 + k));
    run_cycle(0, 1, 0);
    run_cycle(1, 1, 0);
    @(negedge fifo_rd_clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("reset_mid_run");
    @(posedge fifo_rd_clk);
    #1;
    check_reset_values("reset_mid_run_held");
    @(negedge fifo_rd_clk);
    rst_n = 1'b1;
    run_cycle(0, 0, 0);
    vectors++;
    if (ctl_state !== 2'd0 || fifo_rd_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got state=%0d rd_en=%b expected 0 0", ctl_state, fifo_rd_en);
    end
  endtask

  task automatic test_random_traffic();
    bit req;
    bit en;
    bit clr;
    $display("[TB] test_random_traffic");
    cnt_force = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1) src_q.push_back(DW'($urandom));
      cnt_force_val = $urandom_range(START - 6, START + 6);
      req = ($urandom_range(0, 99) < 70);
      en  = ($urandom_range(0, 149) != 0);
      clr = ($urandom_range(0, 99) == 0);
      run_cycle(req, en, clr);
    end
    cnt_force = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_prime_threshold();
    test_stream_order();
    test_underflow();
    test_saturation();
    test_write_into_empty();
    test_flush_reenable();
    test_reset_mid_run();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
